// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core: phase encoding, NOP word and fetch FSM states.
package core_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WRITE  = 3'd4;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel: one-cycle request pulse, variable-latency valid/data return.
interface fetch_unit_if #(
  parameter int IMEM_AW = 16
);
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic               imem_valid;
  logic [31:0]        imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/pc_reg.sv
// Program counter with once-per-WRITE commit, sticky misalign flag and, under
// FETCH_INSTRET_EN, a 64-bit retired-instruction counter.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign
`ifdef FETCH_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  assign pc_plus4 = pc + 32'd4;

  // Branch targets are word-aligned by dropping the low bits; the flag records that it happened.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (commit) begin
      if (branch_taken) begin
        pc <= {branch_target[31:2], 2'b00};
        if (branch_target[1:0] != 2'b00) misalign <= 1'b1;
      end else begin
        pc <= pc_plus4;
      end
    end
  end

`ifdef FETCH_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst) instret <= 64'd0;
    else if (commit) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one imem request per FETCH phase and latches the returned word.
// Optional FETCH_INSTRET_EN adds the instret counter output.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  fetch_unit_if.master imem,
  output logic [31:0] instr_raw,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        misalign
`ifdef FETCH_INSTRET_EN
  ,
  output logic [63:0] instret
`endif
);

  fetch_state_e fsm, fsm_nxt;
  logic [2:0]   prev_state;
  logic         fetch_start;
  logic         commit;
  logic         accept;
  logic         req;

  // Phase entry is edge-detected so long phases trigger exactly one action.
  assign fetch_start = (state == ST_FETCH) && (prev_state != ST_FETCH);
  assign commit      = (state == ST_WRITE) && (prev_state != ST_WRITE);
  assign accept      = (fsm == FS_WAIT) && (state == ST_FETCH) && imem.imem_valid;

  // pc cannot change during FETCH, so the address is naturally held across WAIT.
  assign imem.imem_addr = pc[IMEM_AW+1:2];
  assign imem.imem_req  = req;

  always_comb begin
    fsm_nxt = fsm;
    req     = 1'b0;
    case (fsm)
      FS_IDLE: if (fetch_start) fsm_nxt = FS_REQ;
      FS_REQ: begin
        req     = 1'b1;
        fsm_nxt = FS_WAIT;
      end
      // A controller abort wins over a coincident response.
      FS_WAIT: if (state != ST_FETCH || imem.imem_valid) fsm_nxt = FS_IDLE;
      default: fsm_nxt = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= FS_IDLE;
      prev_state <= ST_WRITE;
      fetch_done <= 1'b0;
      instr_raw  <= NOP_INSTR;
    end else begin
      fsm        <= fsm_nxt;
      prev_state <= state;
      fetch_done <= accept;
      if (accept) instr_raw <= imem.imem_rdata;
    end
  end

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .commit       (commit),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .misalign     (misalign)
`ifdef FETCH_INSTRET_EN
    ,
    .instret      (instret)
`endif
  );

endmodule
